// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : data_mem_arbiter
// Brief  : Serialises load/store (port C) and DMA/debug (port D) accesses onto
//          one 64-bit big-endian data memory. Define DMEM_ARB_RR_EN for
//          round-robin arbitration; otherwise port C wins every tie.
// Rev    : 1.0  initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int MemSize     = 1024,
  parameter int ReadLatency = 2
) (
  input  logic        Clock,
  input  logic        ResetL,
  input  logic        CReq,
  input  logic        CWrite,
  input  logic [63:0] CAddr,
  input  logic [63:0] CWData,
  output logic        CAck,
  output logic [63:0] CRData,
  output logic        CErr,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [63:0] DAddr,
  input  logic [63:0] DWData,
  output logic        DAck,
  output logic [63:0] DRData,
  output logic        DErr,
  output logic [63:0] MemAddress,
  output logic [63:0] MemWriteData,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  input  logic [63:0] MemReadData,
  output logic        Busy,
  output logic        GrantD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [64:0] c_mem_size = 65'(MemSize);
  localparam logic [3:0]  c_latency  = 4'(ReadLatency);

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nx;
  logic        r_write;
  logic        r_err;
  logic        w_pick_d;
  logic        w_grant;
  logic        w_sel_write;
  logic [63:0] w_sel_addr;
  logic [63:0] w_sel_wdata;
  logic [64:0] w_sel_end;
  logic        w_range_err;

`ifdef DMEM_ARB_RR_EN
  logic r_last_d;

  always_comb begin
    w_pick_d = DReq & (~CReq | ~r_last_d);
  end

  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      r_last_d <= 1'b1;
    end else if (w_grant) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  always_comb begin
    w_pick_d = DReq & ~CReq;
  end
`endif

  // Ack cycle is IDLE but must not regrant: a held Req only counts one cycle later.
  always_comb begin
    w_sel_write = w_pick_d ? DWrite : CWrite;
    w_sel_addr  = w_pick_d ? DAddr  : CAddr;
    w_sel_wdata = w_pick_d ? DWData : CWData;
    w_sel_end   = {1'b0, w_sel_addr} + 65'd7;
    w_range_err = (w_sel_end >= c_mem_size);
    w_grant     = (r_state == IDLE) && (CReq || DReq) && !(CAck || DAck);
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nx = w_range_err ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        w_state_nx = WAIT;
        w_cnt_nx   = c_latency;
      end
      WAIT: begin
        w_cnt_nx = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      MemoryRead   <= 1'b0;
      MemoryWrite  <= 1'b0;
      Busy         <= 1'b0;
      GrantD       <= 1'b0;
      CAck         <= 1'b0;
      DAck         <= 1'b0;
      CErr         <= 1'b0;
      DErr         <= 1'b0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      MemAddress   <= 64'd0;
      MemWriteData <= 64'd0;
      CRData       <= 64'd0;
      DRData       <= 64'd0;
    end else begin
      MemoryRead  <= w_grant && !w_range_err && !w_sel_write;
      MemoryWrite <= w_grant && !w_range_err && w_sel_write;
      Busy        <= (w_state_nx != IDLE);
      CAck        <= (r_state == DONE) && !GrantD;
      DAck        <= (r_state == DONE) && GrantD;
      CErr        <= (r_state == DONE) && !GrantD && r_err;
      DErr        <= (r_state == DONE) && GrantD && r_err;
      if (w_grant) begin
        GrantD       <= w_pick_d;
        r_write      <= w_sel_write;
        r_err        <= w_range_err;
        MemAddress   <= w_sel_addr;
        MemWriteData <= w_sel_wdata;
      end
      if ((r_state == DONE) && !r_write && !r_err) begin
        if (GrantD) begin
          DRData <= MemReadData;
        end else begin
          CRData <= MemReadData;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_arbiter
// Brief  : Directed self-checking bench for data_mem_arbiter with a byte-array
//          memory model (two-stage registered read path).
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;

  logic        Clock;
  logic        ResetL;
  logic        CReq, CWrite, DReq, DWrite;
  logic [63:0] CAddr, CWData, DAddr, DWData;
  logic        CAck, CErr, DAck, DErr;
  logic [63:0] CRData, DRData;
  logic [63:0] MemAddress, MemWriteData, MemReadData;
  logic        MemoryRead, MemoryWrite, Busy, GrantD;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:1023];
  logic [63:0] rd_q1, rd_q2;

  data_mem_arbiter #(.MemSize(1024), .ReadLatency(2)) dut (
    .Clock(Clock), .ResetL(ResetL),
    .CReq(CReq), .CWrite(CWrite), .CAddr(CAddr), .CWData(CWData),
    .CAck(CAck), .CRData(CRData), .CErr(CErr),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData), .DErr(DErr),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .MemReadData(MemReadData), .Busy(Busy), .GrantD(GrantD)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = {w[55:0], mem[10'(a + 64'(i))]};
    return w;
  endfunction

  // Big-endian byte memory; reads come out two edges after the strobe.
  always @(posedge Clock) begin
    if (MemoryWrite)
      for (int i = 0; i < 8; i++) mem[10'(MemAddress + 64'(i))] <= MemWriteData[63-8*i -: 8];
    if (MemoryRead) rd_q1 <= mem_word(MemAddress);
    rd_q2 <= rd_q1;
  end
  assign MemReadData = rd_q2;

  // Drives one request and watches until its Ack (bounded at 20 cycles).
  task automatic run_txn(input bit use_d, input bit wr, input logic [63:0] addr,
                         input logic [63:0] wdata, output int ack_cyc, output int n_rd,
                         output int n_wr, output int strobe_cyc, output logic [63:0] s_addr,
                         output logic [63:0] s_wdata, output logic [63:0] rdata,
                         output logic err, output int other_ack);
    ack_cyc = -1; n_rd = 0; n_wr = 0; strobe_cyc = -1; s_addr = '0; s_wdata = '0;
    rdata = '0; err = 1'b0; other_ack = 0;
    @(negedge Clock);
    if (use_d) begin DReq = 1; DWrite = wr; DAddr = addr; DWData = wdata; end
    else       begin CReq = 1; CWrite = wr; CAddr = addr; CWData = wdata; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (MemoryRead)  n_rd++;
      if (MemoryWrite) n_wr++;
      if (MemoryRead || MemoryWrite) begin
        strobe_cyc = k; s_addr = MemAddress; s_wdata = MemWriteData;
      end
      if (use_d ? CAck : DAck) other_ack++;
      if (use_d ? DAck : CAck) begin
        ack_cyc = k;
        rdata   = use_d ? DRData : CRData;
        err     = use_d ? DErr : CErr;
        break;
      end
    end
    CReq = 0; DReq = 0;
    @(negedge Clock);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    ResetL = 0;
    @(negedge Clock);
    ResetL = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    n_cmp++; if ({CAck, DAck, CErr, DErr} !== 4'b0) begin n_fail++;
      $display("FAIL reset_acks: got %b expected 0000", {CAck, DAck, CErr, DErr}); end
    n_cmp++; if ({MemoryRead, MemoryWrite, Busy, GrantD} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {MemoryRead, MemoryWrite, Busy, GrantD}); end
    n_cmp++; if ({MemAddress, MemWriteData} !== 128'd0) begin n_fail++;
      $display("FAIL reset_mem_bus: got %h %h expected 0", MemAddress, MemWriteData); end
    n_cmp++; if ({CRData, DRData} !== 128'd0) begin n_fail++;
      $display("FAIL reset_rdata: got %h %h expected 0", CRData, DRData); end
    ResetL = 1;
    repeat (3) @(negedge Clock);
    n_cmp++; if ({Busy, MemoryRead, MemoryWrite, CAck, DAck} !== 5'b0) begin n_fail++;
      $display("FAIL idle_after_reset: got %b expected 00000", {Busy, MemoryRead, MemoryWrite, CAck, DAck}); end
  endtask

  task automatic test_c_read();
    int ack, nr, nw, sc, oa; logic [63:0] sa, sw, rd; logic er;
    run_txn(0, 0, 64'h18, 64'h0, ack, nr, nw, sc, sa, sw, rd, er, oa);
    n_cmp++; if (ack !== 5) begin n_fail++; $display("FAIL c_read_ack_cycle: got %0d expected 5", ack); end
    n_cmp++; if (nr !== 1 || nw !== 0) begin n_fail++;
      $display("FAIL c_read_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", nr, nw); end
    n_cmp++; if (sc !== 1) begin n_fail++; $display("FAIL c_read_strobe_cycle: got %0d expected 1", sc); end
    n_cmp++; if (sa !== 64'h18) begin n_fail++; $display("FAIL c_read_addr: got %h expected 18", sa); end
    n_cmp++; if (rd !== 64'h0ffbea7deadbeeff) begin n_fail++;
      $display("FAIL c_read_data: got %h expected 0ffbea7deadbeeff", rd); end
    n_cmp++; if (er !== 1'b0 || oa !== 0) begin n_fail++;
      $display("FAIL c_read_err_other: got err=%b dack=%0d expected 0 0", er, oa); end
  endtask

  task automatic test_d_write_c_read();
    int ack, nr, nw, sc, oa; logic [63:0] sa, sw, rd; logic er;
    run_txn(1, 1, 64'h20, 64'h1122334455667788, ack, nr, nw, sc, sa, sw, rd, er, oa);
    n_cmp++; if (ack !== 5) begin n_fail++; $display("FAIL d_write_ack_cycle: got %0d expected 5", ack); end
    n_cmp++; if (nw !== 1 || nr !== 0) begin n_fail++;
      $display("FAIL d_write_strobes: got rd=%0d wr=%0d expected rd=0 wr=1", nr, nw); end
    n_cmp++; if (sa !== 64'h20 || sw !== 64'h1122334455667788) begin n_fail++;
      $display("FAIL d_write_bus: got addr=%h data=%h expected 20 1122334455667788", sa, sw); end
    n_cmp++; if (oa !== 0 || er !== 1'b0) begin n_fail++;
      $display("FAIL d_write_other: got cack=%0d derr=%b expected 0 0", oa, er); end
    run_txn(0, 0, 64'h20, 64'h0, ack, nr, nw, sc, sa, sw, rd, er, oa);
    n_cmp++; if (rd !== 64'h1122334455667788) begin n_fail++;
      $display("FAIL c_readback: got %h expected 1122334455667788", rd); end
    n_cmp++; if (DRData !== 64'h0) begin n_fail++;
      $display("FAIL d_rdata_untouched: got %h expected 0", DRData); end
  endtask

  task automatic test_back_to_back();
    int gport [4]; int gcyc [4]; int ng; int nd;
    int exp_port [4];
`ifdef DMEM_ARB_RR_EN
    exp_port = '{0, 1, 0, 1};
`else
    exp_port = '{0, 0, 0, 0};
`endif
    do_reset();
    ng = 0; nd = 0;
    @(negedge Clock);
    CReq = 1; CWrite = 0; CAddr = 64'h18;
    DReq = 1; DWrite = 0; DAddr = 64'h20;
    for (int k = 1; k <= 23; k++) begin
      @(negedge Clock);
      if (DAck) nd++;
      if ((CAck || DAck) && ng < 4) begin gport[ng] = DAck ? 1 : 0; gcyc[ng] = k; ng++; end
    end
    CReq = 0; DReq = 0;
    repeat (3) @(negedge Clock);
    n_cmp++; if (ng !== 4) begin n_fail++; $display("FAIL b2b_grant_count: got %0d expected 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++; if (gport[i] !== exp_port[i] || gcyc[i] !== 5 + 6*i) begin n_fail++;
        $display("FAIL b2b_grant%0d: got port=%0d cyc=%0d expected port=%0d cyc=%0d",
                 i, gport[i], gcyc[i], exp_port[i], 5 + 6*i); end
    end
`ifndef DMEM_ARB_RR_EN
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL b2b_d_starved: got dack=%0d expected 0", nd); end
`endif
    n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b expected 0", Busy); end
  endtask

  task automatic test_range_err();
    int ack, nr, nw, sc, oa; logic [63:0] sa, sw, rd; logic er;
    logic [63:0] addrs [2];
    addrs = '{64'h3FC, 64'hFFFFFFFFFFFFFFFC};
    for (int i = 0; i < 2; i++) begin
      run_txn(0, 0, addrs[i], 64'h0, ack, nr, nw, sc, sa, sw, rd, er, oa);
      n_cmp++; if (ack !== 2) begin n_fail++; $display("FAIL range%0d_ack_cycle: got %0d expected 2", i, ack); end
      n_cmp++; if (nr + nw !== 0) begin n_fail++; $display("FAIL range%0d_strobes: got %0d expected 0", i, nr + nw); end
      n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL range%0d_err: got %b expected 1", i, er); end
    end
    run_txn(0, 0, 64'h3F8, 64'h0, ack, nr, nw, sc, sa, sw, rd, er, oa);
    n_cmp++; if (er !== 1'b0 || nr !== 1 || ack !== 5) begin n_fail++;
      $display("FAIL range_edge_ok: got err=%b rd=%0d ack=%0d expected 0 1 5", er, nr, ack); end
  endtask

  task automatic test_reset_mid();
    int acks; int ack, nr, nw, sc, oa; logic [63:0] sa, sw, rd; logic er;
    @(negedge Clock);
    CReq = 1; CWrite = 0; CAddr = 64'h18;
    repeat (3) @(negedge Clock);
    n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", Busy); end
    ResetL = 0;
    #1;
    n_cmp++; if ({Busy, MemoryRead, MemoryWrite} !== 3'b0) begin n_fail++;
      $display("FAIL rmid_async_clear: got %b expected 000", {Busy, MemoryRead, MemoryWrite}); end
    CReq = 0;
    @(negedge Clock);
    ResetL = 1;
    acks = 0;
    repeat (10) begin @(negedge Clock); if (CAck) acks++; end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rmid_no_ack: got %0d expected 0", acks); end
    run_txn(0, 0, 64'h20, 64'h0, ack, nr, nw, sc, sa, sw, rd, er, oa);
    n_cmp++; if (ack !== 5 || rd !== 64'h1122334455667788) begin n_fail++;
      $display("FAIL rmid_reissue: got ack=%0d data=%h expected 5 1122334455667788", ack, rd); end
  endtask

  task automatic test_req_drop();
    int acks, strobes, ack_cyc;
    acks = 0; strobes = 0; ack_cyc = -1;
    @(negedge Clock);
    CReq = 1; CWrite = 0; CAddr = 64'h18;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clock);
      if (MemoryRead || MemoryWrite) strobes++;
      if (CAck) begin acks++; ack_cyc = k; end
      if (k == 2) CReq = 0;
    end
    n_cmp++; if (acks !== 1 || ack_cyc !== 5) begin n_fail++;
      $display("FAIL drop_ack: got count=%0d cyc=%0d expected 1 5", acks, ack_cyc); end
    n_cmp++; if (strobes !== 1 || Busy !== 1'b0) begin n_fail++;
      $display("FAIL drop_strobes_idle: got strobes=%0d busy=%b expected 1 0", strobes, Busy); end
    n_cmp++; if (CRData !== 64'h0ffbea7deadbeeff) begin n_fail++;
      $display("FAIL drop_data: got %h expected 0ffbea7deadbeeff", CRData); end
  endtask

  initial begin
    ResetL = 0;
    CReq = 0; CWrite = 0; CAddr = '0; CWData = '0;
    DReq = 0; DWrite = 0; DAddr = '0; DWData = '0;
    rd_q1 = '0; rd_q2 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    begin
      logic [63:0] seed;
      seed = 64'h0ffbea7deadbeeff;
      for (int i = 0; i < 8; i++) mem[24 + i] = seed[63-8*i -: 8];
    end
    test_reset();
    test_c_read();
    test_d_write_c_read();
    test_back_to_back();
    test_range_err();
    test_reset_mid();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer for the 64-bit big-endian byte-addressed data memory. The processor load/store stage (port C) and a DMA/debug loader (port D) share one memory. The block serialises their requests and drives the memory strobes for exactly one cycle. It waits out the memory's registered read delay, then returns data and a one-cycle acknowledge to the granted requester. It sits between the MEM pipeline stage and the data memory instance.

## Interface
Parameters:
- MemSize, 1024: memory depth in bytes; legal accesses need Addr+7 < MemSize.
- ReadLatency, 2: cycles waited after the strobe cycle before ReadData is captured; legal range 1-15.

Ports:
- Clock  in  1  single clock, rising edge.
- ResetL  in  1  asynchronous, active-low reset.
- CReq / DReq  in  1  request, held until the matching Ack.
- CWrite / DWrite  in  1  1 = write, 0 = read; stable while Req.
- CAddr / DAddr  in  64  byte address; stable while Req.
- CWData / DWData  in  64  write data; stable while Req.
- CAck / DAck  out  1  one-cycle completion pulse.
- CRData / DRData  out  64  read data, valid in the Ack cycle, held until the next read completes on that port.
- CErr / DErr  out  1  valid with Ack: address out of range, no memory access made.
- MemAddress  out  64  address to memory.
- MemWriteData  out  64  write data to memory.
- MemoryRead / MemoryWrite  out  1  memory strobes, mutually exclusive.
- MemReadData  in  64  memory ReadData.
- Busy  out  1  state != IDLE.
- GrantD  out  1  0 = port C owns the current or last transaction, 1 = port D.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All state and outputs are registered.
- IDLE:
  - No Req asserted: stay in IDLE.
  - Otherwise select a port (see Configuration) and latch its Write, Addr and WData into MemAddress and MemWriteData. Set GrantD.
  - Range check: (Addr + 7) >= MemSize, or any of Addr[63:10] set with the default MemSize, counts as an error. Do the compare in 65 bits so that Addr+7 does not wrap.
  - On error: go directly to DONE with Err=1 and no strobe.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): MemoryRead = !Write or MemoryWrite = Write. Load wait counter with ReadLatency, then go to WAIT.
- WAIT: decrement the counter. At 0 go to DONE. Writes also wait, so a following read never races the delayed memory update.
- DONE (1 cycle): pulse Ack for the granted port. On a read without error, capture MemReadData into that port's RData. Return to IDLE.
- The Ack of the non-granted port stays 0. The Err of the non-granted port is 0.
- If Req drops before Ack (protocol violation), the latched transaction still completes and Ack still pulses.
- A request held through Ack is treated as a new request in the following IDLE cycle. A requester must drop Req in the cycle after Ack if it has no further request.

Reset values: state IDLE; all Ack, Err, strobes, Busy and GrantD = 0; MemAddress, MemWriteData, CRData and DRData = 0; round-robin pointer = "D last" (C wins first).

Reset mid-operation: the transaction is abandoned immediately. No Ack is issued, and the strobes drop asynchronously. The requester must re-issue. A write in ISSUE may or may not land in memory.

## Timing
- Req sampled in IDLE at edge 0 → ISSUE at edge 1 → WAIT for ReadLatency cycles → DONE.
- Req → Ack = ReadLatency + 3 cycles (5 by default).
- Error path: Req → Ack = 2 cycles.
- Throughput: one transaction per ReadLatency + 4 cycles, because IDLE is re-entered between transactions.
- Strobe width is exactly one cycle. MemAddress and MemWriteData are stable from ISSUE through DONE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. When both ports request in IDLE, grant the port not granted last. A 1-bit pointer updates on every grant, including error grants.
- DMEM_ARB_RR_EN undefined: fixed priority, port C always wins a tie. Port D can starve. The pointer logic is absent.

## Test plan
- C read at 0x18 after reset, ReadLatency=2 → one MemoryRead pulse at cycle 1, CAck at cycle 5, CRData = 0x0ffbea7deadbeeff, CErr=0.
- D writes 0x1122334455667788 to 0x20, then C reads 0x20 → one MemoryWrite pulse with MemAddress=0x20, DAck, then CRData = 0x1122334455667788.
- Both ports request reads continuously for 4 transactions → with RR_EN grants are C,D,C,D. Without RR_EN all grants are C and DAck never occurs.
- C read at 0x3FC (0x3FC+7 ≥ 1024), and separately at 0xFFFFFFFFFFFFFFFC → no strobe, CAck two cycles after Req, CErr=1.
- ResetL pulsed low during WAIT of a C read → Busy=0 and strobes=0 immediately, no CAck. A re-issued read completes normally.
- C Req dropped during WAIT → CAck still pulses once, then the block returns to IDLE with no further strobe.
